// File: rtl/rx_frame_parser_if.sv
// Receive-side bundle for rx_frame_parser: octet stream in, payload stream and
// frame descriptors out. The master modport is the parser, slave is its environment.
interface rx_frame_parser_if #(
    parameter int LEN_W = 16
);
    logic [7:0]       byte_i;
    logic             byte_valid;
    logic             rx_er;
    logic             crs_dv;
    logic [7:0]       pay_data;
    logic             pay_valid;
    logic             desc_valid;
    logic             desc_ready;
    logic [LEN_W-1:0] desc_len;
    logic [15:0]      desc_type;
    logic [47:0]      desc_src_mac;
    logic [3:0]       desc_status;

    modport master (
        input  byte_i, byte_valid, rx_er, crs_dv, desc_ready,
        output pay_data, pay_valid, desc_valid, desc_len, desc_type, desc_src_mac, desc_status
    );

    modport slave (
        output byte_i, byte_valid, rx_er, crs_dv, desc_ready,
        input  pay_data, pay_valid, desc_valid, desc_len, desc_type, desc_src_mac, desc_status
    );
endinterface

// File: rtl/rx_frame_parser.sv
// RMII receive frame parser: header extraction, payload forwarding, per-frame descriptor FIFO.
// Optional destination-MAC filtering is compiled in by defining RX_MAC_FILTER_EN.
module rx_frame_parser #(
    parameter int LEN_W      = 16,
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1518,
    parameter int DESC_DEPTH = 4,
    parameter int EOF_GAP    = 4
) (
    input  logic              clk_50_mhz,
    input  logic              rst_n,
    rx_frame_parser_if.master bus,
    input  logic [47:0]       local_mac,
    output logic [15:0]       drop_count
);
    localparam int AW = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int GW = $clog2(EOF_GAP + 1);

    typedef enum logic [2:0] {SYNC, IDLE, HDR, PAYLOAD, DISCARD, FINISH} state_t;
    state_t state_reg, state_next;

    logic [GW-1:0]    gap_reg;
    logic [LEN_W-1:0] cnt_reg, cnt_inc;
    logic [111:0]     hdr_flat;
    logic             runt_reg, long_reg, err_reg;
    logic [7:0]       pay_data_reg;
    logic             pay_valid_reg;
    logic [15:0]      drop_reg;
    logic [CW-1:0]    fill_reg, fill_after;
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic             eof, start_frame, store_hdr, count_pay, push, pop, drop_inc, runt_eof;
    logic             full_chk, filter_reject, desc_valid_int, emit_pay;
    logic [47:0]      dst_mac;
    logic [3:0]       status_now;

    logic [LEN_W-1:0] len_mem    [DESC_DEPTH];
    logic [15:0]      type_mem   [DESC_DEPTH];
    logic [47:0]      src_mem    [DESC_DEPTH];
    logic [3:0]       status_mem [DESC_DEPTH];

    assign eof        = (gap_reg == GW'(EOF_GAP));
    assign cnt_inc    = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
    assign push       = (state_reg == FINISH);
    assign desc_valid_int = (fill_reg != '0);
    assign pop        = desc_valid_int && bus.desc_ready;
    // Occupancy after this cycle's push/pop, so a byte landing in FINISH sees the new entry.
    assign fill_after = fill_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign full_chk   = (fill_after == CW'(DESC_DEPTH));
    assign emit_pay   = count_pay && (cnt_reg < LEN_W'(MAX_LEN));
    assign dst_mac    = hdr_flat[111:64];
    assign status_now = {&dst_mac, err_reg, long_reg, runt_reg || (cnt_reg < LEN_W'(MIN_LEN))};

`ifdef RX_MAC_FILTER_EN
    logic [47:0] dst_cand;
    assign dst_cand      = {hdr_flat[111:72], bus.byte_i};
    assign filter_reject = (dst_cand != local_mac) && (dst_cand != 48'hFFFF_FFFF_FFFF);
`else
    logic unused_local_mac;
    assign unused_local_mac = ^local_mac;
    assign filter_reject    = 1'b0;
`endif

    always_ff @(posedge clk_50_mhz) begin
        if (!rst_n) state_reg <= SYNC;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        store_hdr   = 1'b0;
        count_pay   = 1'b0;
        drop_inc    = 1'b0;
        runt_eof    = 1'b0;
        case (state_reg)
            SYNC: if (eof) state_next = IDLE;
            IDLE, FINISH: begin
                state_next = IDLE;
                if (bus.byte_valid) begin
                    if (full_chk) begin
                        state_next = DISCARD;
                        drop_inc   = 1'b1;
                    end else begin
                        state_next  = HDR;
                        start_frame = 1'b1;
                    end
                end
            end
            HDR: begin
                if (bus.byte_valid) begin
                    store_hdr = 1'b1;
                    if (cnt_reg == LEN_W'(5) && filter_reject) state_next = DISCARD;
                    else if (cnt_reg == LEN_W'(13))            state_next = PAYLOAD;
                end else if (eof) begin
                    state_next = FINISH;
                    runt_eof   = 1'b1;
                end
            end
            PAYLOAD: begin
                if (bus.byte_valid) count_pay  = 1'b1;
                else if (eof)       state_next = FINISH;
            end
            DISCARD: if (eof) state_next = IDLE;
            default: state_next = SYNC;
        endcase
    end

    // Header octets 0..13; octet 0 sits in the top byte of hdr_flat.
    genvar gi;
    for (gi = 0; gi < 14; gi++) begin : g_hdr
        logic [7:0] octet_reg;
        always_ff @(posedge clk_50_mhz) begin
            if (!rst_n)                                     octet_reg <= '0;
            else if (start_frame)                           octet_reg <= (gi == 0) ? bus.byte_i : 8'h00;
            else if (store_hdr && cnt_reg == LEN_W'(gi))    octet_reg <= bus.byte_i;
        end
        assign hdr_flat[8*(13-gi) +: 8] = octet_reg;
    end

    always_ff @(posedge clk_50_mhz) begin
        if (!rst_n) begin
            gap_reg       <= '0;
            cnt_reg       <= '0;
            runt_reg      <= 1'b0;
            long_reg      <= 1'b0;
            err_reg       <= 1'b0;
            pay_data_reg  <= '0;
            pay_valid_reg <= 1'b0;
            drop_reg      <= '0;
            fill_reg      <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            if (bus.crs_dv || bus.byte_valid) gap_reg <= '0;
            else if (!eof)                    gap_reg <= gap_reg + 1'b1;

            if (start_frame)                 cnt_reg <= LEN_W'(1);
            else if (store_hdr || count_pay) cnt_reg <= cnt_inc;

            if (start_frame) begin
                runt_reg <= 1'b0;
                long_reg <= 1'b0;
                err_reg  <= 1'b0;
            end else begin
                if (runt_eof)                 runt_reg <= 1'b1;
                if (count_pay && !emit_pay)   long_reg <= 1'b1;
                if (bus.rx_er && (state_reg == HDR || state_reg == PAYLOAD)) err_reg <= 1'b1;
            end

            pay_valid_reg <= emit_pay;
            if (emit_pay) pay_data_reg <= bus.byte_i;

            if (drop_inc && !(&drop_reg)) drop_reg <= drop_reg + 1'b1;

            fill_reg <= fill_after;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_50_mhz) begin
        if (push) begin
            len_mem[wr_ptr_reg]    <= cnt_reg;
            type_mem[wr_ptr_reg]   <= hdr_flat[15:0];
            src_mem[wr_ptr_reg]    <= hdr_flat[63:16];
            status_mem[wr_ptr_reg] <= status_now;
        end
    end

    // First-word fall-through view, forced to zero while empty.
    assign bus.desc_valid   = desc_valid_int;
    assign bus.desc_len     = desc_valid_int ? len_mem[rd_ptr_reg]    : '0;
    assign bus.desc_type    = desc_valid_int ? type_mem[rd_ptr_reg]   : '0;
    assign bus.desc_src_mac = desc_valid_int ? src_mem[rd_ptr_reg]    : '0;
    assign bus.desc_status  = desc_valid_int ? status_mem[rd_ptr_reg] : '0;
    assign bus.pay_data     = pay_data_reg;
    assign bus.pay_valid    = pay_valid_reg;
    assign drop_count       = drop_reg;
endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser: scoreboard queues for payload octets and descriptors.
`timescale 1ns/1ps
module tb_rx_frame_parser;
    localparam logic [47:0] LOCAL = 48'h0200_0000_00AA;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER = 48'h0200_0000_00BB;
    localparam logic [47:0] SRC1  = 48'h0200_0000_0001;

    logic        clk_50_mhz = 1'b0;
    logic        rst_n      = 1'b0;
    logic [47:0] local_mac  = LOCAL;
    logic [15:0] drop_count;

    rx_frame_parser_if #(.LEN_W(16)) bus ();

    rx_frame_parser #(
        .LEN_W(16), .MIN_LEN(60), .MAX_LEN(1518), .DESC_DEPTH(4), .EOF_GAP(4)
    ) dut (
        .clk_50_mhz (clk_50_mhz),
        .rst_n      (rst_n),
        .bus        (bus),
        .local_mac  (local_mac),
        .drop_count (drop_count)
    );

    always #10 clk_50_mhz = ~clk_50_mhz;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] typ;
        logic [47:0] src;
        logic [3:0]  st;
    } desc_t;

    desc_t      desc_q[$];
    logic [7:0] pay_q[$];
    int         n_vec   = 0;
    int         n_miss  = 0;
    int         pay_cnt = 0;
    desc_t      mon_d;
    logic [7:0] mon_b;

    // Payload scoreboard
    always @(negedge clk_50_mhz) begin
        if (bus.pay_valid === 1'b1) begin
            pay_cnt++;
            n_vec++;
            if (pay_q.size() == 0) begin
                n_miss++;
                $display("FAIL pay_unexpected: got %02h, want no pay_valid", bus.pay_data);
            end else begin
                mon_b = pay_q.pop_front();
                if (bus.pay_data !== mon_b) begin
                    n_miss++;
                    $display("FAIL pay_data: got %02h want %02h", bus.pay_data, mon_b);
                end
            end
        end
    end

    // Descriptor scoreboard, one line per popped descriptor
    always @(negedge clk_50_mhz) begin
        if (bus.desc_valid === 1'b1 && bus.desc_ready === 1'b1) begin
            n_vec++;
            if (desc_q.size() == 0) begin
                n_miss++;
                $display("FAIL desc_unexpected: got len=%0d type=%04h src=%012h st=%04b, want none",
                         bus.desc_len, bus.desc_type, bus.desc_src_mac, bus.desc_status);
            end else begin
                mon_d = desc_q.pop_front();
                if ({bus.desc_len, bus.desc_type, bus.desc_src_mac, bus.desc_status} !== mon_d) begin
                    n_miss++;
                    $display("FAIL desc_fields: got len=%0d type=%04h src=%012h st=%04b want len=%0d type=%04h src=%012h st=%04b",
                             bus.desc_len, bus.desc_type, bus.desc_src_mac, bus.desc_status,
                             mon_d.len, mon_d.typ, mon_d.src, mon_d.st);
                end else begin
                    $display("desc len=%0d type=%04h src=%012h st=%04b ok",
                             bus.desc_len, bus.desc_type, bus.desc_src_mac, bus.desc_status);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_50_mhz);
            #1;
        end
    endtask

    function automatic logic [7:0] octet(input logic [47:0] dst, input logic [47:0] src,
                                         input logic [15:0] et, input int k, input logic [7:0] seed);
        if (k < 6)        return dst[8*(5-k) +: 8];
        else if (k < 12)  return src[8*(11-k) +: 8];
        else if (k == 12) return et[15:8];
        else if (k == 13) return et[7:0];
        else              return 8'(k * 7) ^ seed;
    endfunction

    // One octet every other cycle, crs_dv high for the whole frame, then a 10-cycle gap.
    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                              input int len, input int er_idx, input int rst_idx,
                              input bit expect_desc, input logic [7:0] seed);
        logic [7:0] b;
        bit         pay_ok;
        desc_t      d;
        for (int k = 0; k < len; k++) begin
            b = octet(dst, src, et, k, seed);
            if (k == rst_idx) rst_n = 1'b0;
            bus.byte_i     = b;
            bus.byte_valid = 1'b1;
            bus.crs_dv     = 1'b1;
            bus.rx_er      = (k == er_idx);
            pay_ok = (rst_idx >= 0) ? (k < rst_idx) : expect_desc;
            if (pay_ok && k >= 14 && k < 1518) pay_q.push_back(b);
            idle(1);
            bus.byte_valid = 1'b0;
            bus.rx_er      = 1'b0;
            idle(1);
            if (k == rst_idx) rst_n = 1'b1;
        end
        bus.crs_dv = 1'b0;
        if (expect_desc && rst_idx < 0) begin
            d.len = 16'(len);
            d.typ = et;
            d.src = src;
            d.st  = {dst == BCAST, (er_idx >= 1 && er_idx < len), len > 1518, len < 60};
            desc_q.push_back(d);
        end
        idle(10);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (desc_q.size() != 0 || pay_q.size() != 0); i++) idle(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.byte_i = '0; bus.byte_valid = 1'b0; bus.rx_er = 1'b0; bus.crs_dv = 1'b0;
        bus.desc_ready = 1'b1;
        idle(3);
        n_vec++; if (bus.pay_valid !== 1'b0)     begin n_miss++; $display("FAIL rst_pay_valid: got %b want 0", bus.pay_valid); end
        n_vec++; if (bus.desc_valid !== 1'b0)    begin n_miss++; $display("FAIL rst_desc_valid: got %b want 0", bus.desc_valid); end
        n_vec++; if (drop_count !== 16'd0)       begin n_miss++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
        n_vec++; if (bus.pay_data !== 8'd0)      begin n_miss++; $display("FAIL rst_pay_data: got %02h want 00", bus.pay_data); end
        n_vec++; if (bus.desc_len !== 16'd0)     begin n_miss++; $display("FAIL rst_desc_len: got %0d want 0", bus.desc_len); end
        n_vec++; if (bus.desc_type !== 16'd0)    begin n_miss++; $display("FAIL rst_desc_type: got %04h want 0000", bus.desc_type); end
        n_vec++; if (bus.desc_src_mac !== 48'd0) begin n_miss++; $display("FAIL rst_desc_src: got %012h want 0", bus.desc_src_mac); end
        n_vec++; if (bus.desc_status !== 4'd0)   begin n_miss++; $display("FAIL rst_desc_status: got %04b want 0000", bus.desc_status); end
        rst_n = 1'b1;
        idle(8);
    endtask

    task automatic test_broadcast64();
        int p0 = pay_cnt;
        send_frame(BCAST, SRC1, 16'h0800, 64, -1, -1, 1'b1, 8'h11);
        wait_drain();
        n_vec++; if (pay_cnt - p0 != 50)  begin n_miss++; $display("FAIL bcast64_pay_count: got %0d want 50", pay_cnt - p0); end
        n_vec++; if (desc_q.size() != 0)  begin n_miss++; $display("FAIL bcast64_desc_left: got %0d want 0", desc_q.size()); end
    endtask

    task automatic test_runt20();
        int p0 = pay_cnt;
        send_frame(LOCAL, SRC1, 16'h86DD, 20, -1, -1, 1'b1, 8'h22);
        wait_drain();
        n_vec++; if (pay_cnt - p0 != 6)   begin n_miss++; $display("FAIL runt20_pay_count: got %0d want 6", pay_cnt - p0); end
        n_vec++; if (desc_q.size() != 0)  begin n_miss++; $display("FAIL runt20_desc_left: got %0d want 0", desc_q.size()); end
    endtask

    task automatic test_min_boundary();
        int p0 = pay_cnt;
        send_frame(LOCAL, SRC1, 16'h0806, 60, -1, -1, 1'b1, 8'h33);
        send_frame(LOCAL, SRC1, 16'h0806, 59, -1, -1, 1'b1, 8'h34);
        wait_drain();
        n_vec++; if (pay_cnt - p0 != 91)  begin n_miss++; $display("FAIL min_pay_count: got %0d want 91", pay_cnt - p0); end
        n_vec++; if (desc_q.size() != 0)  begin n_miss++; $display("FAIL min_desc_left: got %0d want 0", desc_q.size()); end
    endtask

    task automatic test_long_rx_er();
        int p0 = pay_cnt;
        send_frame(LOCAL, SRC1, 16'h0800, 1530, 100, -1, 1'b1, 8'h44);
        wait_drain();
        n_vec++; if (pay_cnt - p0 != 1504) begin n_miss++; $display("FAIL long_pay_count: got %0d want 1504", pay_cnt - p0); end
        n_vec++; if (desc_q.size() != 0)   begin n_miss++; $display("FAIL long_desc_left: got %0d want 0", desc_q.size()); end
    endtask

    task automatic test_max_boundary();
        int p0 = pay_cnt;
        send_frame(LOCAL, SRC1, 16'h0800, 1518, -1, -1, 1'b1, 8'h55);
        send_frame(LOCAL, SRC1, 16'h0800, 1519, -1, -1, 1'b1, 8'h56);
        wait_drain();
        n_vec++; if (pay_cnt - p0 != 3008) begin n_miss++; $display("FAIL max_pay_count: got %0d want 3008", pay_cnt - p0); end
        n_vec++; if (desc_q.size() != 0)   begin n_miss++; $display("FAIL max_desc_left: got %0d want 0", desc_q.size()); end
    endtask

    task automatic test_back_to_back();
        int p0 = pay_cnt;
        bus.desc_ready = 1'b0;
        for (int f = 0; f < 5; f++)
            send_frame(LOCAL, SRC1 + 48'(f), 16'h0800 + 16'(f), 64, -1, -1, f < 4, 8'(f));
        n_vec++; if (desc_q.size() != 4)    begin n_miss++; $display("FAIL b2b_held: got %0d want 4", desc_q.size()); end
        n_vec++; if (bus.desc_valid !== 1'b1) begin n_miss++; $display("FAIL b2b_desc_valid: got %b want 1", bus.desc_valid); end
        n_vec++; if (drop_count !== 16'd1)  begin n_miss++; $display("FAIL b2b_drop_count: got %0d want 1", drop_count); end
        n_vec++; if (pay_cnt - p0 != 200)   begin n_miss++; $display("FAIL b2b_pay_count: got %0d want 200", pay_cnt - p0); end
        bus.desc_ready = 1'b1;
        wait_drain();
        idle(1);
        n_vec++; if (desc_q.size() != 0)    begin n_miss++; $display("FAIL b2b_desc_left: got %0d want 0", desc_q.size()); end
        n_vec++; if (bus.desc_valid !== 1'b0) begin n_miss++; $display("FAIL b2b_empty: got %b want 0", bus.desc_valid); end
    endtask

    task automatic test_reset_mid();
        int p0 = pay_cnt;
        send_frame(LOCAL, SRC1, 16'h0800, 64, -1, 30, 1'b0, 8'h66);
        n_vec++; if (drop_count !== 16'd0)    begin n_miss++; $display("FAIL rmid_drop_count: got %0d want 0", drop_count); end
        n_vec++; if (bus.desc_valid !== 1'b0) begin n_miss++; $display("FAIL rmid_desc_valid: got %b want 0", bus.desc_valid); end
        send_frame(LOCAL, SRC1 + 48'h10, 16'h0801, 64, -1, -1, 1'b1, 8'h67);
        wait_drain();
        n_vec++; if (pay_cnt - p0 != 66)  begin n_miss++; $display("FAIL rmid_pay_count: got %0d want 66", pay_cnt - p0); end
        n_vec++; if (desc_q.size() != 0)  begin n_miss++; $display("FAIL rmid_desc_left: got %0d want 0", desc_q.size()); end
    endtask

    task automatic test_filter();
        int p0 = pay_cnt;
        int want_pay;
        bit other_ok;
`ifdef RX_MAC_FILTER_EN
        other_ok = 1'b0;
`else
        other_ok = 1'b1;
`endif
        want_pay = other_ok ? 150 : 100;
        send_frame(LOCAL, SRC1 + 48'h20, 16'h0800, 64, -1, -1, 1'b1, 8'h77);
        send_frame(BCAST, SRC1 + 48'h21, 16'h0800, 64, -1, -1, 1'b1, 8'h78);
        send_frame(OTHER, SRC1 + 48'h22, 16'h0800, 64, -1, -1, other_ok, 8'h79);
        wait_drain();
        n_vec++; if (pay_cnt - p0 != want_pay) begin n_miss++; $display("FAIL filter_pay_count: got %0d want %0d", pay_cnt - p0, want_pay); end
        n_vec++; if (desc_q.size() != 0)       begin n_miss++; $display("FAIL filter_desc_left: got %0d want 0", desc_q.size()); end
        n_vec++; if (drop_count !== 16'd0)     begin n_miss++; $display("FAIL filter_drop_count: got %0d want 0", drop_count); end
    endtask

    initial begin
        test_reset();
        test_broadcast64();
        test_runt20();
        test_min_boundary();
        test_long_rx_er();
        test_max_boundary();
        test_back_to_back();
        test_reset_mid();
        test_filter();
        n_vec++; if (pay_q.size() != 0) begin n_miss++; $display("FAIL pay_left: got %0d want 0", pay_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/rx_frame_parser.md
Name: rx_frame_parser

Overview:
- Parametrised RMII receive frame parser. Sits after the RMII byte receiver, in the clk_50_mhz domain.
- Counts octets per frame and extracts destination MAC, source MAC and EtherType. Forwards payload bytes to a downstream payload FIFO.
- Queues one status descriptor per frame in an internal descriptor FIFO. Re-arms automatically frame after frame; no reset is needed between frames.

Parameters:
- LEN_W, 16, width of octet counter and descriptor length field
- MIN_LEN, 60, minimum legal frame length in octets (without FCS handling)
- MAX_LEN, 1518, maximum legal frame length in octets
- DESC_DEPTH, 4, descriptor FIFO entries (power of two, >=2)
- EOF_GAP, 4, consecutive cycles of crs_dv low with no byte_valid that end a frame

Ports:
- clk_50_mhz  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- byte_i  in  8  received octet from RMII receiver
- byte_valid  in  1  byte_i valid, single-cycle pulse per octet
- rx_er  in  1  PHY receive error
- crs_dv  in  1  carrier sense / data valid
- local_mac  in  48  station address (used only with filter option)
- pay_data  out  8  payload octet (octet index >= 14)
- pay_valid  out  1  pay_data valid, one cycle per octet
- desc_valid  out  1  descriptor FIFO not empty
- desc_ready  in  1  pop descriptor when desc_valid && desc_ready
- desc_len  out  LEN_W  total octets of frame, header included
- desc_type  out  16  EtherType (octets 12,13; octet 12 = [15:8])
- desc_src_mac  out  48  source MAC (octets 6..11; octet 6 = [47:40])
- desc_status  out  4  [0] runt, [1] too long, [2] rx_er seen, [3] broadcast dst
- drop_count  out  16  frames dropped because the descriptor FIFO was full; saturating

Behaviour:
- Reset: state SYNC, counters 0, descriptor FIFO emptied.
  - Outputs after reset: pay_valid=0, desc_valid=0, drop_count=0, pay_data=0, desc_* fields=0.
- Reset mid-frame: everything is cleared. The remainder of that frame is ignored via SYNC.
- States: SYNC, IDLE, HDR, PAYLOAD, DISCARD, FINISH.
- Gap counter: counts consecutive cycles with crs_dv=0 && byte_valid=0. Cleared by either input being high. Saturates at EOF_GAP. The counter reaching EOF_GAP is the "eof" event.
- SYNC -> IDLE on eof. All bytes are ignored in SYNC.
- IDLE, first byte_valid:
  - Descriptor FIFO full: -> DISCARD, drop_count+1 (saturating at 16'hFFFF).
  - Otherwise: -> HDR, octet counter=1, byte stored as octet 0.
  - Free space is checked only here. Only one frame is in flight, so the space is guaranteed at FINISH.
- HDR:
  - Each byte_valid stores the octet at index counter and increments counter.
  - After octet 13 is stored -> PAYLOAD.
  - eof in HDR -> FINISH; runt set.
- PAYLOAD:
  - Each byte_valid: pay_data=byte_i, pay_valid=1 on the next cycle (1-cycle registered latency); counter increments.
  - If the counter would exceed MAX_LEN: status[1] set, pay_valid suppressed for that and all later bytes. Counting continues, saturating at 2^LEN_W-1.
  - eof -> FINISH.
- DISCARD: no pay_valid, no descriptor; -> IDLE on eof.
- FINISH (one cycle): push descriptor, -> IDLE.
  - desc_len = counter.
  - runt = counter < MIN_LEN.
  - broadcast = destination MAC is all ones.
- rx_er high on any cycle in HDR/PAYLOAD sets status[2]. Bytes keep flowing.
- Descriptor FIFO: first-word fall-through; desc_* fields are valid whenever desc_valid=1. A push and a pop in the same cycle are both honoured. A pop when empty is ignored.
- A byte_valid arriving in the FINISH cycle belongs to the next frame: it is treated as the first byte in IDLE, and the FIFO full check applies.

Optional Feature:
- Macro RX_MAC_FILTER_EN.
- Defined:
  - After octet 5, a destination that is neither local_mac nor broadcast sends the block -> DISCARD. No descriptor is written and drop_count is unchanged.
  - Payload for filtered frames is never emitted, since filtering completes before octet 14.
- Undefined: every frame is accepted; local_mac is unused.

Test Plan:
- 64-octet frame with dst FF:FF:FF:FF:FF:FF, src 02:00:00:00:00:01, type 0x0800 -> 50 pay_valid pulses; one descriptor with len=64, type=0x0800, src=0x020000000001, status=4'b1000.
- 20-octet frame -> desc_len=20, status[0]=1, 6 payload bytes.
- 1530-octet frame, rx_er pulsed at octet 100 -> desc_len=1530, status=4'b0110, pay_valid count=1504.
- desc_ready held 0, 5 back-to-back frames with DESC_DEPTH=4 -> 4 descriptors held, drop_count=1, no pay_valid for frame 5; then pop all, in order.
- rst_n asserted mid-payload, crs_dv still high -> remaining bytes ignored; next complete frame after eof reported normally.
- With RX_MAC_FILTER_EN: local_mac=02:00:00:00:00:AA; frames to ...AA, to broadcast, and to ...BB -> 2 descriptors, third frame produces no pay_valid.
